// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: modes, FSM states, initial patterns.
// Pure declarations, no timing; nothing here carries flow control.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam logic [7:0] INIT_COUNT  = 8'h00;
  localparam logic [7:0] INIT_SCAN   = 8'h01;
  localparam logic [7:0] INIT_BLINK  = 8'hFF;
  localparam logic [7:0] INIT_ROTATE = 8'h01;

  function automatic logic [7:0] init_pattern(input mode_e m);
    logic [7:0] p;
    p = INIT_COUNT;
    case (m)
      MODE_COUNT:  p = INIT_COUNT;
      MODE_SCAN:   p = INIT_SCAN;
      MODE_BLINK:  p = INIT_BLINK;
      MODE_ROTATE: p = INIT_ROTATE;
      default:     p = INIT_COUNT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: one-cycle tick_o once the count reaches 2^(BASE_SHIFT+rate_i)-1.
// Tick is combinational from the count register; hold_i freezes the count, clear_i zeroes it and wins.
module led_prescaler #(
  parameter int BASE_SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rate_i,
  input  logic       hold_i,
  input  logic       clear_i,
  output logic       tick_o
);

  localparam int CW = BASE_SHIFT + 7;

  logic [CW-1:0] cnt_q, cnt_d, term;
  logic          at_term;

  // Low BASE_SHIFT+rate bits set; at the widest rate the shift empties the word and term is all ones.
  assign term    = ~({CW{1'b1}} << (BASE_SHIFT + int'(rate_i)));
  assign at_term = (cnt_q >= term);
  assign tick_o  = at_term && !hold_i && !clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (hold_i)  cnt_d = cnt_q;
    else if (at_term) cnt_d = '0;
    else              cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sequencer.sv
// 8-LED pattern sequencer: synchronised switches, prescaler tick, mode FSM; TICK/LEDs one edge after a tick.
// Switch edges act SYNC_STAGES+1 edges later; no backpressure. LED_SEQUENCER_PWM_EN adds BRIGHT dimming.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int BASE_SHIFT  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       NOTRESET,
  input  logic [1:0] MODE,
  input  logic [2:0] RATE,
  input  logic       PAUSE,
`ifdef LED_SEQUENCER_PWM_EN
  input  logic [3:0] BRIGHT,
`endif
  output logic       TICK,
  output logic       LED7,
  output logic       LED6,
  output logic       LED5,
  output logic       LED4,
  output logic       LED3,
  output logic       LED2,
  output logic       LED1,
  output logic       LED0
);

`ifdef LED_SEQUENCER_PWM_EN
  localparam int SW = 10;
`else
  localparam int SW = 6;
`endif

  logic [SW-1:0] sync_in;
  logic [SW-1:0] sync_q [SYNC_STAGES];

`ifdef LED_SEQUENCER_PWM_EN
  assign sync_in = {BRIGHT, PAUSE, RATE, MODE};
`else
  assign sync_in = {PAUSE, RATE, MODE};
`endif

  always_ff @(posedge clk or negedge NOTRESET) begin
    if (!NOTRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  mode_e      mode_s;
  logic [2:0] rate_s;
  logic       pause_s;

  assign mode_s  = mode_e'(sync_q[SYNC_STAGES-1][1:0]);
  assign rate_s  = sync_q[SYNC_STAGES-1][4:2];
  assign pause_s = sync_q[SYNC_STAGES-1][5];

  state_e     state_q;
  mode_e      mode_q;
  logic [7:0] pat_q;
  logic       dir_down_q;
  logic       tick_q;

  logic       mode_chg, presc_clear, presc_tick;
  logic [7:0] pat_adv;
  logic       dir_adv;

  // A mode change outranks both a coincident tick and pause: the prescaler is cleared instead.
  assign mode_chg    = (state_q != ST_LOAD) && (mode_s != mode_q);
  assign presc_clear = mode_chg || (state_q == ST_LOAD);

  led_prescaler #(.BASE_SHIFT(BASE_SHIFT)) u_presc (
    .clk     (clk),
    .rst_n   (NOTRESET),
    .rate_i  (rate_s),
    .hold_i  (pause_s),
    .clear_i (presc_clear),
    .tick_o  (presc_tick)
  );

  always_comb begin
    pat_adv = pat_q;
    dir_adv = dir_down_q;
    case (mode_q)
      MODE_COUNT:  pat_adv = pat_q + 8'd1;
      MODE_SCAN: begin
        if (!dir_down_q) begin
          if (pat_q == 8'h80) begin
            pat_adv = 8'h40;
            dir_adv = 1'b1;
          end else begin
            pat_adv = pat_q << 1;
          end
        end else begin
          if (pat_q == 8'h01) begin
            pat_adv = 8'h02;
            dir_adv = 1'b0;
          end else begin
            pat_adv = pat_q >> 1;
          end
        end
      end
      MODE_BLINK:  pat_adv = ~pat_q;
      MODE_ROTATE: pat_adv = {pat_q[6:0], pat_q[7]};
      default:     pat_adv = pat_q;
    endcase
  end

  always_ff @(posedge clk or negedge NOTRESET) begin
    if (!NOTRESET) begin
      state_q    <= ST_RUN;
      mode_q     <= MODE_COUNT;
      pat_q      <= INIT_COUNT;
      dir_down_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_LOAD: state_q <= pause_s ? ST_HOLD : ST_RUN;
        default: begin
          if (mode_chg) begin
            state_q    <= ST_LOAD;
            mode_q     <= mode_s;
            pat_q      <= init_pattern(mode_s);
            dir_down_q <= 1'b0;
          end else begin
            state_q <= pause_s ? ST_HOLD : ST_RUN;
            if (presc_tick) begin
              pat_q      <= pat_adv;
              dir_down_q <= dir_adv;
              tick_q     <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign TICK = tick_q;

`ifdef LED_SEQUENCER_PWM_EN
  logic [3:0] pwm_q;
  logic [3:0] bright_s;
  logic       pwm_on;

  assign bright_s = sync_q[SYNC_STAGES-1][9:6];
  assign pwm_on   = (pwm_q <= bright_s);

  always_ff @(posedge clk or negedge NOTRESET) begin
    if (!NOTRESET) pwm_q <= 4'd0;
    else           pwm_q <= pwm_q + 4'd1;
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = pat_q & {8{pwm_on}};
`else
  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = pat_q;
`endif

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Pattern controller for the 8-LED bank. Replaces the ripple-clock divider feeding the blinker.
- Single clock domain. A programmable prescaler produces a one-cycle tick enable.
- A mode FSM advances one of four LED patterns on each tick, with pause and run-time mode/rate switching from board switches.

Parameters:
- BASE_SHIFT, 16: tick period is 2^(BASE_SHIFT+RATE) clk cycles.
- SYNC_STAGES, 2: synchroniser depth on MODE, RATE and PAUSE (minimum 2).

Ports:
- clk  in  1  system clock
- NOTRESET  in  1  reset
- MODE  in  2  pattern select (async switch): 0 count, 1 scan, 2 blink, 3 rotate
- RATE  in  3  speed select (async switch), 0 fastest
- PAUSE  in  1  freeze pattern and prescaler (async switch)
- TICK  out  1  one-cycle pulse, coincident with each pattern advance
- LED7..LED0  out  1 each  LED drive, LED7 = pattern bit 7

Behaviour:
- Clocking and reset: one clock, clk. NOTRESET is asynchronous and active-low.
- Reset values: LED7..LED0 = 0, TICK = 0, prescaler = 0, active mode = count, scan direction = up, synchroniser flops = 0.
- Input synchronisers: MODE, RATE and PAUSE each pass through SYNC_STAGES flops. All logic below uses the synced values.
- Prescaler: counter width BASE_SHIFT+7. Terminal T = 2^(BASE_SHIFT+RATE) - 1.
  - When counter >= T: tick is asserted and the counter clears, else the counter increments.
  - The >= compare means a RATE reduction mid-count ticks on the next cycle, never after a wrap.
- FSM states: RUN, HOLD, LOAD.
  - RUN: prescaler counts. On tick, pattern advances and TICK = 1 in the following cycle, together with the new LED value.
  - HOLD: entered when synced PAUSE = 1. Prescaler and pattern are frozen, TICK = 0. Returns to RUN when PAUSE = 0 and the count resumes from the held value.
  - LOAD: entered from RUN or HOLD when synced MODE != active mode. Lasts one cycle.
    - Loads the active mode, its initial pattern and direction = up. Clears the prescaler. TICK = 0.
    - Next state is HOLD if PAUSE = 1, else RUN.
- Simultaneous events: mode change beats tick and pause. A tick that coincides with LOAD is discarded.
- Initial patterns: count 0x00, scan 0x01, blink 0xFF, rotate 0x01.
- Advance rules:
  - count: +1 mod 256, so 0xFF wraps to 0x00.
  - scan: shift in the current direction. At 0x80 the direction flips to down and the next value is 0x40. At 0x01 with direction down, the direction flips to up and the next value is 0x02. Exactly one LED is lit.
  - blink: bitwise invert (0xFF <-> 0x00).
  - rotate: rotate left, 0x80 -> 0x01.
- Latency:
  - A switch edge at the pins affects state SYNC_STAGES+1 edges later.
  - After reset release the first tick occurs after 2^(BASE_SHIFT+RATE) cycles.
- Reset mid-operation: LEDs and TICK clear immediately (asynchronously). No tick is pending after release.

Optional Feature:
- Macro: LED_SEQUENCER_PWM_EN.
- Defined:
  - Adds input BRIGHT (4 bits, passed through the synchroniser) and a free-running 4-bit PWM counter. The PWM counter is never paused and resets to 0.
  - Each LED = pattern bit AND (pwm_cnt <= BRIGHT). BRIGHT = 15 gives a constant on; BRIGHT = 0 gives a 1/16 duty.
  - Pattern timing and TICK are unchanged.
- Undefined: no BRIGHT port; LEDs are driven directly by the pattern register.

Decomposition:
- Package led_seq_pkg holds:
  - Mode encodings: MODE_COUNT, MODE_SCAN, MODE_BLINK, MODE_ROTATE.
  - Initial-pattern constants per mode.
  - FSM state encoding: ST_RUN, ST_HOLD, ST_LOAD.
- Sub-module led_prescaler: counter, RATE-selected >= terminal compare, hold and clear inputs, tick output.
- FSM and pattern datapath stay in led_sequencer.

Test Plan (BASE_SHIFT = 2, SYNC_STAGES = 2):
- Reset, MODE = 0, RATE = 0, PAUSE = 0 -> TICK every 4 cycles, LEDs 0x01, 0x02, 0x03. After 256 ticks LEDs = 0x00 (wrap).
- MODE = 1 -> LEDs 0x01 after the LOAD cycle, then 0x02 … 0x80, 0x40 … 0x01, 0x02. Always exactly one bit set.
- RATE = 3 (period 32); at counter = 10, set RATE = 0 -> TICK within 1 cycle after the synced RATE change, then every 4 cycles.
- PAUSE = 1 mid-count in rotate mode -> LEDs and TICK frozen for 50 cycles. PAUSE = 0 -> next TICK after the remaining count, not a full period.
- Tick cycle coincides with a synced MODE change to 2 -> no TICK, LEDs = 0xFF, prescaler restarts and the next toggle comes 4 cycles later. Assert NOTRESET = 0 mid-run -> LEDs = 0 immediately.
- With LED_SEQUENCER_PWM_EN, blink mode, BRIGHT = 7 -> while the pattern is 0xFF, LEDs high 8 of every 16 cycles; BRIGHT = 15 -> constant high.
